// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues one memory fetch at a time and
// holds the fetched word for the decoder until it is accepted or redirected.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_count
);

    // Handshakes: mem_req_valid and mem_resp_valid are single-cycle pulses;
    // the decoder side transfers on any cycle where out_valid & out_ready.
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        drop, drop_n;
    logic        req_valid_n;
    logic [31:0] req_addr_n;
    logic        out_valid_n;
    logic [31:0] out_instr_n;
    logic [31:0] out_pc_n;
    logic [31:0] count_n;
    logic [31:0] redir_target;

    assign redir_target = {redirect_pc[31:2], 2'b00};

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        drop_n      = drop;
        req_valid_n = 1'b0;
        req_addr_n  = mem_req_addr;
        out_valid_n = out_valid;
        out_instr_n = out_instr;
        out_pc_n    = out_pc;
        count_n     = fetch_count;

        if (redirect_valid) begin
            pc_n = redir_target;
        end

        case (state)
            S_REQ: begin
                if (!redirect_valid && mem_resp_ready) begin
                    req_valid_n = 1'b1;
                    req_addr_n  = pc;
                    state_n     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    // A response coinciding with a redirect, or one already
                    // marked stale, is thrown away and fetch restarts at pc.
                    if (redirect_valid || drop) begin
                        drop_n  = 1'b0;
                        state_n = S_REQ;
                    end else begin
                        out_valid_n = 1'b1;
                        out_instr_n = mem_resp_data;
                        out_pc_n    = pc;
                        state_n     = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_n = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    out_valid_n = 1'b0;
                    out_instr_n = NOP_INSTR;
                    state_n     = S_REQ;
                end else if (out_ready) begin
                    pc_n        = pc + 32'd4;
                    count_n     = fetch_count + 32'd1;
                    out_valid_n = 1'b0;
                    out_instr_n = NOP_INSTR;
                    state_n     = S_REQ;
                end
            end
            default: begin
                state_n = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_REQ;
            pc            <= RESET_PC;
            drop          <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= 32'h0;
            out_valid     <= 1'b0;
            out_instr     <= NOP_INSTR;
            out_pc        <= 32'h0;
            fetch_count   <= 32'h0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            drop          <= drop_n;
            mem_req_valid <= req_valid_n;
            mem_req_addr  <= req_addr_n;
            out_valid     <= out_valid_n;
            out_instr     <= out_instr_n;
            out_pc        <= out_pc_n;
            fetch_count   <= count_n;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: a table of plain fetches followed by
// hand-written redirect, stall and reset sequences.
module tb_ifetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          BUDGET = 60;

    logic        clk;
    logic        rst_n;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_resp_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_count;

    ifetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_count = 32'h0;
    logic [63:0] exp_q[$];   // {pc, instr} of each fetch expected at the decoder

    typedef struct {
        int          lat;
        logic [31:0] data;
        int          hold;
        logic [31:0] addr;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, {31'h0, mem_req_valid}, 32'h0);
        check({tag, "_req_addr"}, mem_req_addr, 32'h0);
        check({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
        check({tag, "_out_instr"}, out_instr, NOP);
        check({tag, "_out_pc"}, out_pc, 32'h0);
        check({tag, "_count"}, fetch_count, 32'h0);
    endtask

    // Returns at the negedge where the request pulse is visible.
    task automatic wait_req(input logic [31:0] exp_addr);
        bit seen = 0;
        bit quiet = 1;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (out_valid) quiet = 0;
            if (mem_req_valid) begin
                seen = 1;
                break;
            end
        end
        check("req_seen", {31'h0, seen}, 32'h1);
        check("no_out_while_fetching", {31'h0, quiet}, 32'h1);
        if (seen) check("req_addr", mem_req_addr, exp_addr);
    endtask

    task automatic pulse_resp(input int lat, input logic [31:0] data);
        repeat (lat) @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_data  = data;
        @(negedge clk);
        mem_resp_valid = 1'b0;
    endtask

    task automatic respond(input int lat, input logic [31:0] data, input logic [31:0] pc);
        exp_q.push_back({pc, data});
        pulse_resp(lat, data);
    endtask

    task automatic wait_out();
        bit seen = 0;
        for (int i = 0; i < BUDGET; i++) begin
            if (out_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("out_seen", {31'h0, seen}, 32'h1);
        if (seen && exp_q.size() > 0) begin
            check("out_pc", out_pc, exp_q[0][63:32]);
            check("out_instr", out_instr, exp_q[0][31:0]);
        end
    endtask

    task automatic accept(input int hold);
        logic [31:0] i0 = out_instr;
        logic [31:0] p0 = out_pc;
        logic [63:0] e;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_stable",
                  {31'h0, (out_valid && out_instr == i0 && out_pc == p0 &&
                           !mem_req_valid && fetch_count == exp_count)}, 32'h1);
        end
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'h0, 32'h1);
        end else begin
            e = exp_q.pop_front();
            check("xfer_pc", out_pc, e[63:32]);
            check("xfer_instr", out_instr, e[31:0]);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_count = exp_count + 32'd1;
        check("after_xfer_valid", {31'h0, out_valid}, 32'h0);
        check("after_xfer_instr", out_instr, NOP);
        check("fetch_count", fetch_count, exp_count);
    endtask

    initial begin
        vecs[0] = '{lat: 3, data: 32'h0050_0093, hold: 0,  addr: 32'h0};
        vecs[1] = '{lat: 1, data: 32'h1111_1111, hold: 10, addr: 32'h4};
        vecs[2] = '{lat: 2, data: 32'hDEAD_BEEF, hold: 0,  addr: 32'h8};
        vecs[3] = '{lat: 5, data: 32'h0000_0067, hold: 3,  addr: 32'hC};

        rst_n = 1'b0;
        mem_resp_ready = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data = 32'h0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            wait_req(vecs[i].addr);
            respond(vecs[i].lat, vecs[i].data, vecs[i].addr);
            wait_out();
            accept(vecs[i].hold);
        end

        // Redirect while a fetch is in flight: the stale response must vanish.
        wait_req(32'h10);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        redirect_valid = 1'b0;
        pulse_resp(1, 32'hBAD0_0001);
        wait_req(32'h100);
        respond(2, 32'h0010_0113, 32'h100);
        wait_out();
        accept(0);

        // Redirect on the same cycle as the response: no lingering drop.
        wait_req(32'h104);
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'hBAD0_0002;
        @(negedge clk);
        redirect_valid = 1'b0;
        mem_resp_valid = 1'b0;
        wait_req(32'h300);
        respond(1, 32'h0030_0193, 32'h300);
        wait_out();
        accept(0);

        // Redirect beats a simultaneous accept in HOLD.
        wait_req(32'h304);
        respond(2, 32'h0040_0213, 32'h304);
        wait_out();
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        out_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        check("redir_hold_valid", {31'h0, out_valid}, 32'h0);
        check("redir_hold_instr", out_instr, NOP);
        check("redir_hold_count", fetch_count, exp_count);
        wait_req(32'h200);
        respond(3, 32'h0050_0293, 32'h200);
        wait_out();
        accept(2);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_req(32'hFFFF_FFFC);
        respond(1, 32'h0060_0313, 32'hFFFF_FFFC);
        wait_out();
        accept(0);
        wait_req(32'h0);
        respond(1, 32'h0070_0393, 32'h0);
        wait_out();
        accept(0);

        // Memory not ready, then reset in the middle of a fetch.
        mem_resp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("no_req_when_busy", {31'h0, mem_req_valid}, 32'h0);
        end
        mem_resp_ready = 1'b1;
        wait_req(32'h4);
        @(negedge clk);
        rst_n = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'hBAD0_0003;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        exp_count = 32'h0;
        wait_req(32'h0);
        respond(2, 32'h0080_0413, 32'h0);
        wait_out();
        accept(0);

        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
